// File: rtl/mux_share_sched.sv
// Purpose : time-shares one (operand << 2) + 1 compute path between three requesters,
//           with fixed-priority or round-robin grant and saturating per-requester counters.
// Latency : result appears on out_data/out_valid one cycle after the accepting edge.
// Backpr. : while a held result is not taken (FULL & !out_ready) no requester is readied
//           and out_* hold; drain and accept in the same cycle keep the pipe bubble-free.
// Ports   : clk/rst (sync, active-high); req_valid/req_data/req_ready per-requester
//           handshake; mode_fixed selects arbitration; out_valid/out_ready/out_data/out_src
//           result handshake; grant_cnt packs three CNT_W accept counters.
module mux_share_sched #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           req_valid,
  input  logic [3*WIDTH-1:0]   req_data,
  output logic [2:0]           req_ready,
  input  logic                 mode_fixed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [1:0]           out_src,
  output logic [3*CNT_W-1:0]   grant_cnt
);

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

  state_t           r_state;
  logic [1:0]       r_last_grant;
  logic [WIDTH-1:0] r_out_data;
  logic [1:0]       r_out_src;
  logic [CNT_W-1:0] r_cnt [3];

  logic             w_can_accept;
  logic [2:0]       w_grant;
  logic [1:0]       w_sel;
  logic             w_xfer;
  logic [WIDTH-1:0] w_operand;
  logic [WIDTH-1:0] w_result;

  // First valid requester in the order a, b, c, as a one-hot vector.
  function automatic logic [2:0] pick3(input logic [2:0] vld, input logic [1:0] a,
                                       input logic [1:0] b, input logic [1:0] c);
    logic [2:0] res;
    res = 3'b000;
    if (vld[a])      res = 3'b001 << a;
    else if (vld[b]) res = 3'b001 << b;
    else if (vld[c]) res = 3'b001 << c;
    return res;
  endfunction

  assign w_can_accept = (r_state == ST_EMPTY) | out_ready;

  always_comb begin
    w_grant = 3'b000;
    if (mode_fixed) begin
      w_grant = pick3(req_valid, 2'd0, 2'd1, 2'd2);
    end else begin
      // Search begins just after the last requester served, wrapping mod 3.
      case (r_last_grant)
        2'd0:    w_grant = pick3(req_valid, 2'd1, 2'd2, 2'd0);
        2'd1:    w_grant = pick3(req_valid, 2'd2, 2'd0, 2'd1);
        default: w_grant = pick3(req_valid, 2'd0, 2'd1, 2'd2);
      endcase
    end
  end

  // Reset gating keeps ready low for the whole reset interval, not just after the edge.
  assign req_ready = (rst || !w_can_accept) ? 3'b000 : w_grant;
  assign w_xfer    = |(req_valid & req_ready);

  always_comb begin
    w_sel = 2'd0;
    if (w_grant[1])      w_sel = 2'd1;
    else if (w_grant[2]) w_sel = 2'd2;
  end

  assign w_operand = req_data[w_sel*WIDTH +: WIDTH];
  assign w_result  = (w_operand << 2) + WIDTH'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_EMPTY;
      r_out_data   <= '0;
      r_out_src    <= 2'd0;
      r_last_grant <= 2'd2;
      for (int i = 0; i < 3; i++) r_cnt[i] <= '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_xfer) r_state <= ST_FULL;
        end
        default: begin
          if (out_ready && !w_xfer) r_state <= ST_EMPTY;
        end
      endcase
      if (w_xfer) begin
        r_out_data   <= w_result;
        r_out_src    <= w_sel;
        r_last_grant <= w_sel;
        if (r_cnt[w_sel] != {CNT_W{1'b1}}) r_cnt[w_sel] <= r_cnt[w_sel] + CNT_W'(1);
      end
    end
  end

  assign out_valid = (r_state == ST_FULL);
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < 3; i++) grant_cnt[i*CNT_W +: CNT_W] = r_cnt[i];
  end

endmodule

// File: tb/tb_mux_share_sched.sv
module tb_mux_share_sched;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   req_valid;
  logic [3*W-1:0] req_data;
  logic         mode_fixed;
  logic         out_ready;

  logic [2:0]   req_ready, req_ready_s;
  logic         out_valid, out_valid_s;
  logic [W-1:0] out_data, out_data_s;
  logic [1:0]   out_src, out_src_s;
  logic [47:0]  grant_cnt;
  logic [5:0]   grant_cnt_s;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  bit     m_full;
  int     m_data, m_src, m_last;
  int     m_cnt[3];
  int     m_cnt_s[3];

  always #5 clk = ~clk;

  mux_share_sched #(.WIDTH(W), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .mode_fixed(mode_fixed), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_src(out_src),
    .grant_cnt(grant_cnt));

  mux_share_sched #(.WIDTH(W), .CNT_W(2)) u_dut_sat (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready_s), .mode_fixed(mode_fixed), .out_valid(out_valid_s),
    .out_ready(out_ready), .out_data(out_data_s), .out_src(out_src_s),
    .grant_cnt(grant_cnt_s));

  function automatic int cnt16(input int i);
    return int'(grant_cnt[i*16 +: 16]);
  endfunction

  function automatic int cnt2(input int i);
    return int'(grant_cnt_s[i*2 +: 2]);
  endfunction

  function automatic int model_grant();
    if (mode_fixed) begin
      for (int i = 0; i < 3; i++) if (req_valid[i]) return i;
    end else begin
      for (int k = 1; k <= 3; k++) if (req_valid[(m_last + k) % 3]) return (m_last + k) % 3;
    end
    return -1;
  endfunction

  function automatic logic [2:0] model_ready();
    int g;
    if (rst) return 3'b000;
    if (m_full && !out_ready) return 3'b000;
    g = model_grant();
    if (g < 0) return 3'b000;
    return 3'(1 << g);
  endfunction

  // Advance one clock and move the model forward using the inputs present at the edge.
  task automatic tick();
    int g;
    bit acc;
    g   = model_grant();
    acc = !m_full || out_ready;
    @(posedge clk);
    if (rst) begin
      m_full = 0; m_data = 0; m_src = 0; m_last = 2;
      for (int i = 0; i < 3; i++) begin m_cnt[i] = 0; m_cnt_s[i] = 0; end
    end else if (acc && g >= 0) begin
      m_full = 1;
      m_data = ((int'(req_data[g*W +: W]) * 4) + 1) % 256;
      m_src  = g;
      m_last = g;
      if (m_cnt[g] < 65535) m_cnt[g]++;
      if (m_cnt_s[g] < 3) m_cnt_s[g]++;
    end else if (m_full && out_ready) begin
      m_full = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1; req_valid = 0; out_ready = 1; mode_fixed = 0; req_data = '0;
    tick(); tick();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; req_valid = 3'b111; out_ready = 1; mode_fixed = 0; req_data = 24'h0A0B0C;
    #1;
    n_checks++; if (req_ready !== 3'b000) $display("FAIL reset_ready got %b want 000", req_ready); else n_pass++;
    tick(); tick();
    n_checks++; if (req_ready !== 3'b000) $display("FAIL reset_ready_hold got %b want 000", req_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_src !== 2'd0)
      $display("FAIL reset_out got v=%b d=%h s=%0d want 0/00/0", out_valid, out_data, out_src); else n_pass++;
    n_checks++; if (grant_cnt !== 48'h0 || grant_cnt_s !== 6'h0)
      $display("FAIL reset_cnt got %h/%h want 0", grant_cnt, grant_cnt_s); else n_pass++;
    rst = 0; req_valid = 0;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 3'b001; req_data = 24'h000005; out_ready = 1; #1;
    n_checks++; if (req_ready !== 3'b001) $display("FAIL single_ready got %b want 001", req_ready); else n_pass++;
    tick();
    req_valid = 3'b000;
    n_checks++; if (out_valid !== 1'b1 || out_data !== 8'h15 || out_src !== 2'd0)
      $display("FAIL single_out got v=%b d=%h s=%0d want 1/15/0", out_valid, out_data, out_src); else n_pass++;
    n_checks++; if (cnt16(0) !== 1) $display("FAIL single_cnt got %0d want 1", cnt16(0)); else n_pass++;
    tick();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL single_drain got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_truncation();
    req_valid = 3'b001; req_data = 24'h0000C3; out_ready = 1;
    tick();
    req_valid = 3'b000; req_data = 24'h0000FF;   // late change must not leak into held result
    n_checks++; if (out_data !== 8'h0D) $display("FAIL trunc_data got %h want 0d", out_data); else n_pass++;
    tick();
  endtask

  task automatic test_round_robin();
    int exp_seq[6] = '{0, 1, 2, 0, 1, 2};
    do_reset();
    req_valid = 3'b111; out_ready = 1; mode_fixed = 0;
    for (int c = 0; c < 6; c++) begin
      req_data = 24'($urandom);
      #1;
      n_checks++; if (req_ready !== 3'(1 << exp_seq[c]))
        $display("FAIL rr_ready[%0d] got %b want %b", c, req_ready, 3'(1 << exp_seq[c])); else n_pass++;
      tick();
      n_checks++; if (out_valid !== 1'b1 || int'(out_src) !== exp_seq[c] || int'(out_data) !== m_data)
        $display("FAIL rr_out[%0d] got v=%b s=%0d d=%h want 1/%0d/%h", c, out_valid, out_src, out_data, exp_seq[c], m_data);
      else n_pass++;
    end
    req_valid = 0; tick();
  endtask

  task automatic test_fixed();
    do_reset();
    req_valid = 3'b111; out_ready = 1; mode_fixed = 1;
    for (int c = 0; c < 6; c++) begin
      req_data = 24'($urandom); #1;
      n_checks++; if (req_ready !== 3'b001) $display("FAIL fixed_ready[%0d] got %b want 001", c, req_ready); else n_pass++;
      tick();
    end
    n_checks++; if (cnt16(0) !== 6 || cnt16(1) !== 0 || cnt16(2) !== 0)
      $display("FAIL fixed_cnt got %0d/%0d/%0d want 6/0/0", cnt16(0), cnt16(1), cnt16(2)); else n_pass++;
    req_valid = 0; mode_fixed = 0; tick();
  endtask

  task automatic test_backpressure();
    logic [W-1:0] d1;
    do_reset();
    req_valid = 3'b001; req_data = 24'h000005; out_ready = 1;
    tick();
    out_ready = 0; req_valid = 3'b010;
    for (int c = 0; c < 4; c++) begin
      req_data = 24'($urandom); #1;
      n_checks++; if (req_ready !== 3'b000) $display("FAIL bp_ready[%0d] got %b want 000", c, req_ready); else n_pass++;
      mode_fixed = ~mode_fixed;
      tick();
      n_checks++; if (out_valid !== 1'b1 || out_data !== 8'h15 || out_src !== 2'd0)
        $display("FAIL bp_hold[%0d] got v=%b d=%h s=%0d want 1/15/0", c, out_valid, out_data, out_src); else n_pass++;
    end
    out_ready = 1; #1;
    d1 = req_data[W +: W];
    n_checks++; if (req_ready !== 3'b010) $display("FAIL bp_release_ready got %b want 010", req_ready); else n_pass++;
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_src !== 2'd1 || out_data !== W'((d1 << 2) + 1))
      $display("FAIL bp_release_out got v=%b s=%0d d=%h want 1/1/%h", out_valid, out_src, out_data, W'((d1 << 2) + 1));
    else n_pass++;
    req_valid = 0; tick();
  endtask

  task automatic test_saturation_reset();
    do_reset();
    req_valid = 3'b100; out_ready = 1; mode_fixed = 0;
    for (int c = 0; c < 5; c++) begin req_data = 24'($urandom); tick(); end
    n_checks++; if (cnt2(2) !== 3) $display("FAIL sat_cnt2 got %0d want 3", cnt2(2)); else n_pass++;
    n_checks++; if (cnt16(2) !== 5) $display("FAIL sat_cnt16 got %0d want 5", cnt16(2)); else n_pass++;
    out_ready = 0; rst = 1; #1;
    n_checks++; if (req_ready !== 3'b000) $display("FAIL rst_mid_ready got %b want 000", req_ready); else n_pass++;
    tick();
    rst = 0; req_valid = 0;
    n_checks++; if (out_valid !== 1'b0 || out_valid_s !== 1'b0) $display("FAIL rst_mid_valid got %b/%b want 0", out_valid, out_valid_s); else n_pass++;
    n_checks++; if (grant_cnt !== 48'h0 || grant_cnt_s !== 6'h0) $display("FAIL rst_mid_cnt got %h/%h want 0", grant_cnt, grant_cnt_s); else n_pass++;
  endtask

  task automatic test_random();
    int errs = 0;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rst        = ($urandom_range(0, 49) == 0);
      req_valid  = 3'($urandom);
      req_data   = 24'($urandom);
      mode_fixed = 1'($urandom);
      out_ready  = ($urandom_range(0, 3) != 0);
      #1;
      n_checks++; if (req_ready !== model_ready() || req_ready_s !== model_ready())
        $display("FAIL rand_ready[%0d] got %b/%b want %b", c, req_ready, req_ready_s, model_ready()); else n_pass++;
      tick();
      n_checks++;
      if (out_valid !== m_full || (m_full && (int'(out_data) !== m_data || int'(out_src) !== m_src)))
        $display("FAIL rand_out[%0d] got v=%b d=%h s=%0d want %b/%h/%0d", c, out_valid, out_data, out_src, m_full, m_data, m_src);
      else n_pass++;
      n_checks++;
      if (cnt16(0) !== m_cnt[0] || cnt16(1) !== m_cnt[1] || cnt16(2) !== m_cnt[2] ||
          cnt2(0) !== m_cnt_s[0] || cnt2(1) !== m_cnt_s[1] || cnt2(2) !== m_cnt_s[2])
        $display("FAIL rand_cnt[%0d] got %0d/%0d/%0d sat %0d/%0d/%0d want %0d/%0d/%0d sat %0d/%0d/%0d", c,
                 cnt16(0), cnt16(1), cnt16(2), cnt2(0), cnt2(1), cnt2(2),
                 m_cnt[0], m_cnt[1], m_cnt[2], m_cnt_s[0], m_cnt_s[1], m_cnt_s[2]);
      else n_pass++;
    end
    rst = 0;
  endtask

  initial begin
    rst = 1; req_valid = 0; req_data = '0; mode_fixed = 0; out_ready = 1;
    m_full = 0; m_data = 0; m_src = 0; m_last = 2;
    for (int i = 0; i < 3; i++) begin m_cnt[i] = 0; m_cnt_s[i] = 0; end
    #1;
    test_reset();
    test_single();
    test_truncation();
    test_round_robin();
    test_fixed();
    test_backpressure();
    test_saturation_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mux_share_sched.md
MUX_SHARE_SCHED -- requirements
Module: mux_share_sched

Interface
REQ-001 Parameter WIDTH, default 8: data width of every request and result word.
REQ-002 Parameter CNT_W, default 16: width of each per-requester grant counter.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  3  per-requester request valid; bit i = requester i.
REQ-006 req_data  input  3*WIDTH  requester i operand in bits [i*WIDTH +: WIDTH].
REQ-007 req_ready  output  3  per-requester accept; one-hot or zero.
REQ-008 mode_fixed  input  1  1 = fixed priority (0 highest); 0 = round-robin.
REQ-009 out_valid  output  1  result holds a valid word.
REQ-010 out_ready  input  1  downstream accepts result.
REQ-011 out_data  output  WIDTH  shared-unit result.
REQ-012 out_src  output  2  index of the requester that produced out_data.
REQ-013 grant_cnt  output  3*CNT_W  requester i accepted-transfer count in bits [i*CNT_W +: CNT_W].

Function
REQ-014 The block shall time-share one compute path, result = (operand << 2) + 1, truncated to WIDTH bits, between three requesters.
REQ-015 FSM states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-016 can_accept = (state==EMPTY) | out_ready.
REQ-017 Grant selection is combinational from req_valid, mode_fixed and last_grant.
- Fixed mode: lowest valid index wins.
- Round-robin mode: search starts at (last_grant+1) mod 3 and wraps.
REQ-018 req_ready[i] = can_accept & grant[i]; no ready to a non-granted or invalid requester.
REQ-019 A transfer on requester i occurs when req_valid[i] & req_ready[i].
- Next edge: out_data <= result, out_src <= i, state <= FULL, last_grant <= i.
REQ-020 Latency: result visible on out_data/out_valid exactly 1 cycle after the transfer edge.
REQ-021 FULL & out_ready & no transfer: state <= EMPTY, out_valid <= 0.
REQ-022 FULL & out_ready & transfer (simultaneous drain and accept): state stays FULL, out_data/out_src replaced; one transfer per cycle, no bubble.
REQ-023 FULL & !out_ready: req_ready = 0; out_data, out_src and out_valid shall hold stable.
REQ-024 last_grant updates only on a transfer, and in both modes.
REQ-025 grant_cnt[i] increments by 1 on each requester i transfer and saturates at all-ones with no wrap.
REQ-026 mode_fixed may change on any cycle; it takes effect on the same cycle's grant and never corrupts a held result.
REQ-027 req_data is sampled only on the transfer edge; later changes do not affect out_data.

Reset
REQ-028 On rst=1 at a rising edge, the block shall set:
- state = EMPTY, out_valid = 0, out_data = 0, out_src = 0;
- last_grant = 2, so the first round-robin search starts at 0;
- all grant_cnt = 0.
REQ-029 While rst=1, req_ready shall be 0.
REQ-030 Reset mid-operation (FULL with a held result) shall discard the result with no downstream handshake.

Verification
REQ-031 Single request: WIDTH=8, reset, req_valid=001, data0=0x05, out_ready=1 -> req_ready=001; next cycle out_valid=1, out_data=0x15, out_src=0, grant_cnt[0]=1.
REQ-032 Truncation: data=0xC3 -> out_data=0x0D ((0x30C+1) & 0xFF).
REQ-033 Round-robin: req_valid=111 held, out_ready=1, mode_fixed=0 after reset -> grants 0,1,2,0,1,2 on consecutive cycles; out_valid continuously 1 from the 2nd cycle.
REQ-034 Fixed priority: same stimulus with mode_fixed=1 -> requester 0 granted every cycle; grant_cnt[1] and grant_cnt[2] stay 0.
REQ-035 Backpressure: FULL with out_data=0x15, out_ready=0 for 4 cycles, req_valid=010 -> req_ready=000 and out_data stable; on out_ready=1 -> requester 1 transfers the same cycle, next cycle out_src=1.
REQ-036 Saturation and reset: CNT_W=2, 5 transfers on requester 2 -> grant_cnt[2]=3; assert rst while FULL -> next cycle out_valid=0 and all counters 0.
